// File: rtl/shift_register_n_pkg.sv
// Shared mode encodings and sizing helper for the shift_register_n delay line.
package shift_register_pkg;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_SHIFT = 2'b01;
   localparam logic [1:0] MODE_LOAD  = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

   // Bits needed to count 0..depth inclusive.
   function automatic int unsigned fill_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/shift_register_n_if.sv
// Control/data bundle between a datapath driver and the shift_register_n delay line.
interface shift_register_n_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   import shift_register_pkg::*;

   localparam int unsigned FW = fill_width(DEPTH);

   logic [1:0]             mode;
   logic [WIDTH-1:0]       d;
   logic [WIDTH*DEPTH-1:0] load_d;
   logic [WIDTH-1:0]       q;
   logic [WIDTH*DEPTH-1:0] q_all;
   logic [FW-1:0]          fill;
   logic                   primed;

   modport master (output mode, d, load_d, input  q, q_all, fill, primed);
   modport slave  (input  mode, d, load_d, output q, q_all, fill, primed);

endinterface

// File: rtl/shift_register_n_stage.sv
// One WIDTH-bit stage of the delay line: hold, shift, load or clear per mode.
module sr_stage
   import shift_register_pkg::*;
#(
   parameter int unsigned     WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] shift_in,
   input  logic [WIDTH-1:0] load_in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q;
   logic [WIDTH-1:0] stage_d;

   always_comb begin
      stage_d = stage_q;
      unique case (mode)
         MODE_HOLD:  stage_d = stage_q;
         MODE_SHIFT: stage_d = shift_in;
         MODE_LOAD:  stage_d = load_in;
         MODE_CLEAR: stage_d = RESET_VAL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stage_q <= RESET_VAL;
      else          stage_q <= stage_d;
   end

   assign q = stage_q;

endmodule

// File: rtl/shift_register_n.sv
// DEPTH x WIDTH delay line with parallel load, synchronous clear and a saturating fill count.
module shift_register_n
   import shift_register_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   shift_register_n_if.slave bus
);

   localparam int unsigned FW = fill_width(DEPTH);

   logic [WIDTH-1:0]       stage_q [DEPTH];
   logic [WIDTH*DEPTH-1:0] q_all_w;
   logic [FW-1:0]          fill_q;
   logic [FW-1:0]          fill_d;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] shift_in;
      if (i == 0) begin : g_head
         assign shift_in = bus.d;
      end else begin : g_body
         assign shift_in = stage_q[i-1];
      end

      sr_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk      (clk),
         .reset_n  (reset_n),
         .mode     (bus.mode),
         .shift_in (shift_in),
         .load_in  (bus.load_d[i*WIDTH +: WIDTH]),
         .q        (stage_q[i])
      );
   end

   // Saturation test precedes the add, so the count never wraps even at DEPTH = 2^FW-1.
   always_comb begin
      fill_d = fill_q;
      unique case (bus.mode)
         MODE_HOLD:  fill_d = fill_q;
         MODE_SHIFT: if (fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
         MODE_LOAD:  fill_d = FW'(DEPTH);
         MODE_CLEAR: fill_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) fill_q <= '0;
      else          fill_q <= fill_d;
   end

   always_comb begin
      q_all_w = '0;
      for (int i = 0; i < int'(DEPTH); i++) q_all_w[i*WIDTH +: WIDTH] = stage_q[i];
   end

   assign bus.q      = stage_q[DEPTH-1];
   assign bus.q_all  = q_all_w;
   assign bus.fill   = fill_q;
   assign bus.primed = (fill_q == FW'(DEPTH));

endmodule

// File: tb/tb_shift_register_n.sv
// Directed bench for shift_register_n: a 4-deep line and a 1-deep line with non-zero reset value.
module tb_shift_register_n;

   logic clk;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   shift_register_n_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
   shift_register_n_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

   shift_register_n #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut4 (
      .clk(clk), .reset_n(reset_n), .bus(bus4.slave));

   shift_register_n #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus4.mode = 2'b01; bus4.d = 8'hFF; bus4.load_d = '0;
      bus1.mode = 2'b00; bus1.d = 8'h00; bus1.load_d = '0;
      #5;
      checks++; if (bus4.q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", bus4.q); end
      checks++; if (bus4.q_all !== 32'h0) begin errors++; $display("FAIL reset_q_all got=%h exp=00000000", bus4.q_all); end
      checks++; if (bus4.fill !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", bus4.fill); end
      checks++; if (bus4.primed !== 1'b0) begin errors++; $display("FAIL reset_primed got=%b exp=0", bus4.primed); end
      #2;
      reset_n = 1'b1;
      bus4.mode = 2'b00;
   endtask

   task automatic test_shift();
      bus4.mode = 2'b01;
      bus4.d = 8'h11; tick();
      bus4.d = 8'h22; tick();
      bus4.d = 8'h33; tick();
      checks++; if (bus4.fill !== 3'd3) begin errors++; $display("FAIL shift3_fill got=%0d exp=3", bus4.fill); end
      checks++; if (bus4.primed !== 1'b0) begin errors++; $display("FAIL shift3_primed got=%b exp=0", bus4.primed); end
      checks++; if (bus4.q !== 8'h00) begin errors++; $display("FAIL shift3_q got=%h exp=00", bus4.q); end
      bus4.d = 8'h44; tick();
      checks++; if (bus4.q_all !== 32'h11223344) begin errors++; $display("FAIL shift4_q_all got=%h exp=11223344", bus4.q_all); end
      checks++; if (bus4.q !== 8'h11) begin errors++; $display("FAIL shift4_q got=%h exp=11", bus4.q); end
      checks++; if (bus4.fill !== 3'd4) begin errors++; $display("FAIL shift4_fill got=%0d exp=4", bus4.fill); end
      checks++; if (bus4.primed !== 1'b1) begin errors++; $display("FAIL shift4_primed got=%b exp=1", bus4.primed); end
      bus4.d = 8'h55; tick();
      checks++; if (bus4.q !== 8'h22) begin errors++; $display("FAIL shift5_q got=%h exp=22", bus4.q); end
      checks++; if (bus4.q_all !== 32'h22334455) begin errors++; $display("FAIL shift5_q_all got=%h exp=22334455", bus4.q_all); end
      checks++; if (bus4.fill !== 3'd4) begin errors++; $display("FAIL shift5_fill_sat got=%0d exp=4", bus4.fill); end
      bus4.mode = 2'b00;
   endtask

   task automatic test_load_hold();
      bus4.mode = 2'b10; bus4.load_d = 32'hDEADBEEF; tick();
      checks++; if (bus4.q_all !== 32'hDEADBEEF) begin errors++; $display("FAIL load_q_all got=%h exp=deadbeef", bus4.q_all); end
      checks++; if (bus4.q !== 8'hDE) begin errors++; $display("FAIL load_q got=%h exp=de", bus4.q); end
      checks++; if (bus4.fill !== 3'd4) begin errors++; $display("FAIL load_fill got=%0d exp=4", bus4.fill); end
      bus4.mode = 2'b00; bus4.load_d = 32'h0;
      for (int i = 0; i < 3; i++) begin
         bus4.d = (i % 2 == 0) ? 8'hFF : 8'h00;
         tick();
         checks++; if (bus4.q_all !== 32'hDEADBEEF) begin errors++; $display("FAIL hold%0d_q_all got=%h exp=deadbeef", i, bus4.q_all); end
      end
      checks++; if (bus4.fill !== 3'd4) begin errors++; $display("FAIL hold_fill got=%0d exp=4", bus4.fill); end
   endtask

   task automatic test_clear();
      bus4.mode = 2'b11; tick();
      checks++; if (bus4.q_all !== 32'h0) begin errors++; $display("FAIL clear_q_all got=%h exp=00000000", bus4.q_all); end
      checks++; if (bus4.fill !== 3'd0) begin errors++; $display("FAIL clear_fill got=%0d exp=0", bus4.fill); end
      checks++; if (bus4.primed !== 1'b0) begin errors++; $display("FAIL clear_primed got=%b exp=0", bus4.primed); end
      bus4.mode = 2'b01;
      bus4.d = 8'hA1; tick();
      bus4.d = 8'hA2; tick();
      bus4.mode = 2'b00;
      checks++; if (bus4.fill !== 3'd2) begin errors++; $display("FAIL clr_shift_fill got=%0d exp=2", bus4.fill); end
      checks++; if (bus4.primed !== 1'b0) begin errors++; $display("FAIL clr_shift_primed got=%b exp=0", bus4.primed); end
      checks++; if (bus4.q !== 8'h00) begin errors++; $display("FAIL clr_shift_q got=%h exp=00", bus4.q); end
      checks++; if (bus4.q_all !== 32'h0000A1A2) begin errors++; $display("FAIL clr_shift_q_all got=%h exp=0000a1a2", bus4.q_all); end
   endtask

   task automatic test_mid_reset();
      bus4.mode = 2'b01; bus4.d = 8'hA3; tick();
      bus4.mode = 2'b00;
      checks++; if (bus4.fill !== 3'd3) begin errors++; $display("FAIL pre_rst_fill got=%0d exp=3", bus4.fill); end
      #4;
      reset_n = 1'b0;
      #1;
      checks++; if (bus4.q_all !== 32'h0) begin errors++; $display("FAIL async_rst_q_all got=%h exp=00000000", bus4.q_all); end
      checks++; if (bus4.fill !== 3'd0) begin errors++; $display("FAIL async_rst_fill got=%0d exp=0", bus4.fill); end
      #4;
      reset_n = 1'b1;
      bus4.mode = 2'b01; bus4.d = 8'h77; tick();
      bus4.mode = 2'b00;
      checks++; if (bus4.q_all !== 32'h00000077) begin errors++; $display("FAIL post_rst_q_all got=%h exp=00000077", bus4.q_all); end
      checks++; if (bus4.fill !== 3'd1) begin errors++; $display("FAIL post_rst_fill got=%0d exp=1", bus4.fill); end
   endtask

   task automatic test_depth1();
      reset_n = 1'b0; #2; reset_n = 1'b1;
      checks++; if (bus1.q !== 8'h5A) begin errors++; $display("FAIL d1_reset_q got=%h exp=5a", bus1.q); end
      checks++; if (bus1.fill !== 1'b0) begin errors++; $display("FAIL d1_reset_fill got=%0d exp=0", bus1.fill); end
      bus1.mode = 2'b01; bus1.d = 8'hA5; tick();
      checks++; if (bus1.q !== 8'hA5) begin errors++; $display("FAIL d1_shift_q got=%h exp=a5", bus1.q); end
      checks++; if (bus1.q_all !== 8'hA5) begin errors++; $display("FAIL d1_shift_q_all got=%h exp=a5", bus1.q_all); end
      checks++; if (bus1.primed !== 1'b1) begin errors++; $display("FAIL d1_shift_primed got=%b exp=1", bus1.primed); end
      bus1.d = 8'h3C; tick();
      checks++; if (bus1.q !== 8'h3C) begin errors++; $display("FAIL d1_shift2_q got=%h exp=3c", bus1.q); end
      checks++; if (bus1.fill !== 1'b1) begin errors++; $display("FAIL d1_fill_sat got=%0d exp=1", bus1.fill); end
      bus1.mode = 2'b11; tick();
      bus1.mode = 2'b00;
      checks++; if (bus1.q !== 8'h5A) begin errors++; $display("FAIL d1_clear_q got=%h exp=5a", bus1.q); end
      checks++; if (bus1.fill !== 1'b0) begin errors++; $display("FAIL d1_clear_fill got=%0d exp=0", bus1.fill); end
      checks++; if (bus1.primed !== 1'b0) begin errors++; $display("FAIL d1_clear_primed got=%b exp=0", bus1.primed); end
   endtask

   initial begin
      test_reset();
      test_shift();
      test_load_hold();
      test_clear();
      test_mid_reset();
      test_depth1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
